neuron_input_loader: RTL
========================

Name: neuron_input_loader

Overview:
- Upstream feeder for the fixed-point neuron stage.
- Accepts a serial stream of signed fixed-point input values over a VALID/READY handshake and packs NUM_INPUTS of them into one parallel vector.
- Presents that vector with a single-cycle valid pulse, then holds off new input until the neuron reports its result.
- Guarantees at most one inference in flight and a stable vector while the neuron pipeline consumes it.

Parameters:
- NUM_INPUTS, 4, number of values per vector (>=2).
- WIDTH, 8, bits per value (signed fixed point, passed through unchanged).
- FRAC_BITS, 3, fractional bits; informational only, no arithmetic on values.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- S_VALUE_IN  input  WIDTH  signed stream sample.
- S_VALID_IN  input  1  sample valid.
- S_LAST_IN  input  1  marks final sample of a vector.
- S_READY_OUT  output  1  loader can accept a sample.
- VALUES_OUT  output  NUM_INPUTS*WIDTH  packed vector; sample k at [k*WIDTH +: WIDTH].
- VALID_OUT  output  1  one-cycle pulse, vector complete.
- DONE_IN  input  1  neuron result-valid pulse.
- COUNT_OUT  output  $clog2(NUM_INPUTS+1)  samples held in current vector.
- BUSY_OUT  output  1  high in FIRE or WAIT.
- ERR_OUT  output  1  framing error pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset (async assert, sync release): state FILL; VALUES_OUT=0; COUNT_OUT=0; VALID_OUT=0; ERR_OUT=0; S_READY_OUT=1 on the first cycle after release.
- Transfer occurs on a cycle with S_VALID_IN && S_READY_OUT.
- FILL state:
  - S_READY_OUT=1.
  - Each transfer writes S_VALUE_IN into slot COUNT_OUT, then increments COUNT_OUT.
  - The transfer that fills slot NUM_INPUTS-1 moves the state to FIRE.
- FIRE state:
  - Lasts exactly one cycle; VALID_OUT=1; S_READY_OUT=0.
  - Moves to WAIT.
  - Latency: last transfer at edge t, so VALID_OUT is high during cycle t+1.
- WAIT state:
  - S_READY_OUT=0.
  - VALUES_OUT is held stable.
  - On DONE_IN=1: COUNT_OUT clears to 0 and the state moves to FILL; S_READY_OUT=1 the next cycle.
- DONE_IN is ignored in FILL and in FIRE.
- VALUES_OUT slots are not cleared between vectors; they are overwritten in order.
- S_READY_OUT and VALID_OUT are registered; S_READY_OUT never depends combinationally on S_VALID_IN.
- Slots with no transfer keep their value.
- Reset asserted mid-vector or in WAIT: partial data is discarded, all outputs return to reset values, no VALID_OUT is generated.
- BUSY_OUT = (state==FIRE || state==WAIT).

Optional Feature:
- Macro: NEURON_INPUT_LOADER_FRAMING_EN.
- Defined (framing check active):
  - Early LAST: S_LAST_IN=1 on a transfer into slot < NUM_INPUTS-1 discards the partial vector, sets COUNT_OUT=0, stays in FILL, pulses ERR_OUT for one cycle, and produces no VALID_OUT.
  - Missing LAST: S_LAST_IN=0 on the transfer into slot NUM_INPUTS-1 still fires normally, and ERR_OUT pulses in the same cycle as VALID_OUT.
- Not defined: S_LAST_IN is ignored and ERR_OUT is constant 0.

Test Plan (NUM_INPUTS=4, WIDTH=8 unless stated):
1. Reset, then stream 0x08,0xF8,0x10,0x7F back-to-back with LAST on the 4th -> VALID_OUT pulses 1 cycle after the 4th transfer; VALUES_OUT=0x7F10F808; S_READY_OUT=0 until DONE_IN.
2. In WAIT, hold S_VALID_IN=1 for 20 cycles, then pulse DONE_IN -> no transfers and VALUES_OUT stable during WAIT; S_READY_OUT=1 the cycle after DONE_IN; the next vector loads from slot 0.
3. Insert random S_VALID_IN gaps across 3 vectors -> each vector is packed in order; exactly 3 VALID_OUT pulses; COUNT_OUT tracks 0..4.
4. Assert RST after 2 transfers, release, send 4 samples -> the first VALID_OUT reflects only the post-reset samples; COUNT_OUT=0 right after reset.
5. Pulse DONE_IN during FILL with COUNT_OUT=2 -> ignored; COUNT_OUT stays 2 and filling continues.
6. With NEURON_INPUT_LOADER_FRAMING_EN: LAST on the 2nd sample -> ERR_OUT 1-cycle pulse, no VALID_OUT, COUNT_OUT=0. No LAST on the 4th sample -> VALID_OUT and ERR_OUT pulse together. Without the macro: the same stimulus gives ERR_OUT=0, and the early-LAST vector completes after 4 samples.

Source files
------------

// File: rtl/neuron_input_loader.sv
// ============================================================================
//  neuron_input_loader
//  Packs a serial VALID/READY stream of signed fixed-point samples into one
//  parallel vector for the neuron stage and keeps one inference in flight.
//  Optional framing check: define NEURON_INPUT_LOADER_FRAMING_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module neuron_input_loader #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH      = 8,
  parameter int FRAC_BITS  = 3
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [WIDTH-1:0]                   S_VALUE_IN,
  input  logic                               S_VALID_IN,
  input  logic                               S_LAST_IN,
  output logic                               S_READY_OUT,
  output logic [NUM_INPUTS*WIDTH-1:0]        VALUES_OUT,
  output logic                               VALID_OUT,
  input  logic                               DONE_IN,
  output logic [$clog2(NUM_INPUTS+1)-1:0]    COUNT_OUT,
  output logic                               BUSY_OUT,
  output logic                               ERR_OUT
);

  localparam int CNT_W = $clog2(NUM_INPUTS+1);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_INPUTS-1);

  if (NUM_INPUTS < 2 || FRAC_BITS >= WIDTH) begin : g_param_check
    $error("neuron_input_loader: invalid NUM_INPUTS/FRAC_BITS");
  end

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [NUM_INPUTS*WIDTH-1:0]   values_q, values_d;
  logic                          ready_q, ready_d;
  logic                          valid_q, valid_d;
  logic                          err_q, err_d;
  logic                          early_last;
  logic                          missing_last;
  logic                          xfer;

`ifdef NEURON_INPUT_LOADER_FRAMING_EN
  assign early_last   = S_LAST_IN && (count_q != LAST_SLOT);
  assign missing_last = !S_LAST_IN;
`else
  logic last_unused;
  assign last_unused  = S_LAST_IN;
  assign early_last   = 1'b0;
  assign missing_last = 1'b0;
`endif

  assign xfer = S_VALID_IN && ready_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    values_d = values_q;
    err_d    = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (xfer) begin
          if (early_last) begin
            // Partial vector is dropped; stale slot contents get overwritten.
            count_d = '0;
            err_d   = 1'b1;
          end else begin
            for (int k = 0; k < NUM_INPUTS; k++) begin
              if (count_q == CNT_W'(k)) begin
                values_d[k*WIDTH +: WIDTH] = S_VALUE_IN;
              end
            end
            count_d = count_q + 1'b1;
            if (count_q == LAST_SLOT) begin
              state_d = ST_FIRE;
              err_d   = missing_last;
            end
          end
        end
      end
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (DONE_IN) begin
          count_d = '0;
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
    // Handshake outputs come straight from flops, decoded from the next state.
    ready_d = (state_d == ST_FILL);
    valid_d = (state_d == ST_FIRE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_FILL;
      count_q  <= '0;
      values_q <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      values_q <= values_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign S_READY_OUT = ready_q;
  assign VALID_OUT   = valid_q;
  assign VALUES_OUT  = values_q;
  assign COUNT_OUT   = count_q;
  assign ERR_OUT     = err_q;
  assign BUSY_OUT    = (state_q == ST_FIRE) || (state_q == ST_WAIT);

endmodule

`default_nettype wire
